// File: rtl/mem_read_sequencer.sv
// Burst read sequencer for a single-port block RAM: issues a wrapping address burst,
// waits out the read latency, then holds data_rdy until the consumer acknowledges.
module mem_read_sequencer #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              data_done,
    output logic              enable_a,
    output logic [ADDR_W-1:0] dir_A,
    output logic [ADDR_W-1:0] dir_A_buff,
    output logic              valid_buff,
    output logic              data_rdy,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT} state_t;

    localparam int              LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dir_q, dir_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     issue_q, issue_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                aborted_q, aborted_d;
    logic [CNT_W-1:0]    frame_q, frame_d;
    logic [ADDR_W-1:0]   dir_pipe_q [RD_LAT];
    logic [ADDR_W-1:0]   dir_pipe_d [RD_LAT];
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;

    assign enable_a   = (state_q == READ);
    assign data_rdy   = (state_q == WAIT);
    assign dir_A      = dir_q;
    assign dir_A_buff = dir_pipe_q[RD_LAT-1];
    assign valid_buff = vld_pipe_q[RD_LAT-1];
    assign frame_cnt  = frame_q;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        len_d     = len_q;
        issue_d   = issue_q;
        lat_d     = lat_q;
        aborted_d = aborted_q;
        frame_d   = frame_q;
        case (state_q)
            IDLE: begin
                dir_d = '0;
                if (!busy) begin
                    state_d   = READ;
                    dir_d     = base_addr;
                    len_d     = (len == '0 || len > DEPTH) ? DEPTH : len;
                    issue_d   = '0;
                    aborted_d = 1'b0;
                end
            end
            READ: begin
                lat_d = '0;
                if (abort) begin
                    aborted_d = 1'b1;
                end
                // The last (or aborted) read keeps its address so DRAIN holds it.
                if (abort || issue_q == len_q - 1'b1) begin
                    state_d = DRAIN;
                end else begin
                    dir_d   = dir_q + 1'b1;
                    issue_d = issue_q + 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    state_d = (aborted_q || abort) ? IDLE : WAIT;
                    dir_d   = '0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            WAIT: begin
                dir_d = '0;
                if (data_done) begin
                    frame_d = frame_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                dir_d   = '0;
            end
        endcase
    end

    // Delay line keeps address and valid aligned with the memory's output latency.
    always_comb begin
        dir_pipe_d = dir_pipe_q;
        vld_pipe_d = vld_pipe_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            dir_pipe_d[i] = dir_pipe_q[i-1];
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        dir_pipe_d[0] = dir_q;
        vld_pipe_d[0] = enable_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= '0;
            len_q      <= '0;
            issue_q    <= '0;
            lat_q      <= '0;
            aborted_q  <= 1'b0;
            frame_q    <= '0;
            vld_pipe_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dir_pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            len_q      <= len_d;
            issue_q    <= issue_d;
            lat_q      <= lat_d;
            aborted_q  <= aborted_d;
            frame_q    <= frame_d;
            vld_pipe_q <= vld_pipe_d;
            for (int i = 0; i < RD_LAT; i++) begin
                dir_pipe_q[i] <= dir_pipe_d[i];
            end
        end
    end

endmodule

// File: doc/mem_read_sequencer.md
# mem_read_sequencer

Parametrised read sequencer for a single-port block RAM. It issues a burst of `len` consecutive reads starting at `base_addr`, wrapping modulo the memory depth. It then waits out a configurable memory read latency and raises `data_rdy` until the consumer acknowledges with `data_done`. It sits between the frame memory and the downstream processing stage, and supplies a latency-aligned address/valid pair so write-back logic can capture each returned word.

## Interface
- `ADDR_W`, default 6: address width; memory depth `DEPTH = 2**ADDR_W`.
- `RD_LAT`, default 2: memory read latency in cycles, legal range ≥1. Also the length of the `dir_A_buff` / `valid_buff` delay line.
- `CNT_W`, default 16: width of the completed-frame counter.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `busy` in 1: downstream busy. A burst starts from IDLE only while `busy==0`.
- `base_addr` in ADDR_W: first read address. Sampled on the IDLE→READ transition.
- `len` in ADDR_W+1: burst length. Sampled on the IDLE→READ transition. 0 or any value >DEPTH is treated as DEPTH.
- `abort` in 1: stops issuing reads. Honoured in READ and DRAIN only.
- `data_done` in 1: consumer acknowledge. Honoured in WAIT only.
- `enable_a` out 1: memory read enable.
- `dir_A` out ADDR_W: memory read address, registered.
- `dir_A_buff` out ADDR_W: `dir_A` delayed by RD_LAT cycles.
- `valid_buff` out 1: `enable_a` delayed by RD_LAT cycles. Marks the cycle the memory output belongs to `dir_A_buff`.
- `data_rdy` out 1: burst complete and all data returned. Held until accepted.
- `frame_cnt` out CNT_W: number of completed, non-aborted bursts. Wraps modulo 2**CNT_W.

## Operation
- The FSM has four states: IDLE, READ, DRAIN, WAIT.
- **IDLE**
  - `dir_A` is driven to 0.
  - If `busy==0`: latch `base_addr`, latch the effective length L (1..DEPTH), clear the issue counter and the aborted flag, then go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - `enable_a=1`. In the i-th READ cycle (i=0..L-1), `dir_A = (base+i) mod DEPTH`.
  - After the L-th READ cycle, go to DRAIN.
  - If `abort==1` in a READ cycle, that cycle still issues its read. Set the aborted flag and go to DRAIN next cycle.
- **DRAIN**
  - `enable_a=0`, `dir_A` holds its last value, and a latency counter runs for exactly RD_LAT cycles.
  - On the last DRAIN cycle: go to IDLE if the aborted flag is set, otherwise go to WAIT.
  - `abort` in DRAIN sets the aborted flag.
- **WAIT**
  - `data_rdy=1` and `dir_A` is driven to 0.
  - On `data_done==1`: increment `frame_cnt` and go to IDLE. `busy` is ignored in this decision.
  - `abort` is ignored in WAIT.
- `data_done` outside WAIT and `abort` outside READ/DRAIN have no effect.
- The delay line runs in every state, including IDLE and WAIT. It only carries zeros/invalids after a drain.
- Any undefined state encoding returns to IDLE.

## Timing
- Reset values: `enable_a=0`, `dir_A=0`, `dir_A_buff=0`, `valid_buff=0`, `data_rdy=0`, `frame_cnt=0`. State is IDLE, and every delay-line stage is cleared to 0.
- The outputs `enable_a` and `data_rdy` are Moore decodes of the registered state. `dir_A` is a register.
- Start: if `busy` is sampled low in IDLE at edge k, READ is active from edge k, and the first read is (`enable_a=1`, `dir_A=base`) in cycle k..k+1.
- The L reads occupy cycles k..k+L-1. The last `valid_buff` occurs in cycle k+L-1+RD_LAT, which is the last DRAIN cycle.
- `data_rdy` rises in cycle k+L+RD_LAT. Minimum start-to-`data_rdy` latency is L+RD_LAT cycles.
- `data_rdy` drops in the cycle after `data_done` is sampled high, and `frame_cnt` updates on the same edge.
- Back-to-back bursts: if WAIT exits to IDLE with `busy==0`, the next READ begins one cycle later. There is exactly one IDLE cycle between bursts.
- Wrap-around example: base=62, L=4 gives addresses 62, 63, 0, 1.
- Reset mid-burst takes effect on the next edge: all outputs return to their reset values and in-flight delay-line entries are discarded. No `data_rdy` and no `frame_cnt` change results.
- If `abort` and the L-th read fall in the same cycle, the burst is counted as aborted.

## Test plan
- **Reset and basic burst:** reset 3 cycles; then `busy=0`, base=0, len=64, RD_LAT=2 → `enable_a` high for exactly 64 cycles with addresses 0..63; `valid_buff` high for 64 cycles starting 2 cycles after `enable_a` rises, with `dir_A_buff` 0..63; `data_rdy` rises 66 cycles after start; `data_done` pulse → `frame_cnt=1`.
- **Wrap and length clamp:** base=60, len=8 → addresses 60..63, 0..3. With len=0 and len=100 → 64 reads each.
- **Busy hold and handshake:** `busy=1` for 10 cycles → no `enable_a`. Hold `data_done=0` for 20 cycles in WAIT → `data_rdy` stays high and `frame_cnt` is unchanged. `data_done` pulses during READ are ignored.
- **Abort:** len=16, abort on the 5th read → exactly 5 reads and 5 `valid_buff` cycles; return to IDLE after RD_LAT cycles; `data_rdy` never asserts; `frame_cnt` is unchanged.
- **Reset mid-operation:** assert `reset` in the 3rd READ cycle and separately in DRAIN → all outputs 0 on the next cycle, and `valid_buff` stays 0 until a new burst.
- **Parameter sweep:** ADDR_W=4, RD_LAT=1 and RD_LAT=4, back-to-back bursts with `busy=0` → one IDLE cycle between bursts, alignment holds (`dir_A_buff` equals `dir_A` from RD_LAT cycles earlier), and `frame_cnt` wraps correctly at CNT_W=2.
